// File: rtl/pwm_multi.sv
`timescale 1ns/1ps
// Multi-channel PWM: one shared edge/center-aligned period counter, per-channel compare, shadowed mode/period/duty.
// Latency: count -> pwm_out/tick one cycle; free-running, no backpressure (load is a fire-and-forget strobe).
module pwm_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      load,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]       polarity,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      tick,
  output logic                      load_pending,
  output logic [WIDTH-1:0]          count
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [CHANNELS-1:0][WIDTH-1:0] duty_in;
  logic [CHANNELS-1:0][WIDTH-1:0] act_duty;
  logic [CHANNELS-1:0][WIDTH-1:0] shd_duty;
  logic [CHANNELS-1:0][WIDTH-1:0] eff_duty;
  logic [WIDTH-1:0]               act_period;
  logic [WIDTH-1:0]               shd_period;
  logic [WIDTH-1:0]               eff_period;
  logic                           act_mode;
  logic                           shd_mode;
  logic                           eff_mode;

  dir_t                           dir;
  dir_t                           dir_eff;
  dir_t                           dir_nxt;
  logic [WIDTH-1:0]               count_nxt;
  logic [WIDTH-1:0]               lim;
  logic [CHANNELS-1:0]            raw;
  logic [CHANNELS-1:0]            pwm_nxt;

  logic boundary;
  logic take_in;
  logic take_shd;
  logic cap_shd;
  logic period_live;

  assign duty_in  = duty;
  assign boundary = enable && (count == '0);
  assign take_in  = boundary && load;
  // A disabled block has no period to protect, so a pending shadow lands on the next clock.
  assign take_shd = load_pending && !take_in && (boundary || !enable);
  assign cap_shd  = load && !boundary;

  // Parameters that govern the current cycle: freshly applied ones in a boundary cycle.
  always_comb begin
    eff_mode   = act_mode;
    eff_period = act_period;
    eff_duty   = act_duty;
    if (take_in) begin
      eff_mode   = mode;
      eff_period = period;
      eff_duty   = duty_in;
    end else if (take_shd) begin
      eff_mode   = shd_mode;
      eff_period = shd_period;
      eff_duty   = shd_duty;
    end
  end

  assign period_live = enable && (eff_period != '0);
  assign dir_eff     = boundary ? DIR_UP : dir;

  always_comb begin
    count_nxt = '0;
    dir_nxt   = DIR_UP;
    if (enable && (eff_period > WIDTH'(1))) begin
      if (!eff_mode) begin
        if (count >= eff_period - WIDTH'(1)) begin
          count_nxt = '0;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else if (dir_eff == DIR_UP) begin
        if (count >= eff_period - WIDTH'(1)) begin
          count_nxt = count - WIDTH'(1);
          dir_nxt   = DIR_DOWN;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        // Reaching zero on the way down is a boundary, which forces the direction back up.
        count_nxt = count - WIDTH'(1);
        dir_nxt   = DIR_DOWN;
      end
    end
  end

  always_comb begin
    lim = '0;
    raw = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lim    = (eff_duty[i] > eff_period) ? eff_period : eff_duty[i];
      raw[i] = (count < lim);
    end
  end

  assign pwm_nxt = period_live ? (raw ^ polarity) : polarity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      dir          <= DIR_UP;
      tick         <= 1'b0;
      pwm_out      <= '0;
      load_pending <= 1'b0;
      act_mode     <= 1'b0;
      act_period   <= '0;
      act_duty     <= '0;
      shd_mode     <= 1'b0;
      shd_period   <= '0;
      shd_duty     <= '0;
    end else begin
      count        <= count_nxt;
      dir          <= dir_nxt;
      tick         <= period_live && (count == '0);
      pwm_out      <= pwm_nxt;
      load_pending <= cap_shd || (load_pending && !take_in && !take_shd);
      if (take_in || take_shd) begin
        act_mode   <= eff_mode;
        act_period <= eff_period;
        act_duty   <= eff_duty;
      end
      if (cap_shd) begin
        shd_mode   <= mode;
        shd_period <= period;
        shd_duty   <= duty_in;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
`timescale 1ns/1ps
// Directed bench for pwm_multi: a phase-index reference model checked every cycle,
// plus hand-computed high-time / tick counts per period.
module tb_pwm_multi;
  localparam int W  = 16;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic          mode = 1'b0;
  logic [W-1:0]  period = '0;
  logic [CH*W-1:0] duty = '0;
  logic [CH-1:0] polarity = '0;
  logic [CH-1:0] pwm_out;
  logic          tick;
  logic          load_pending;
  logic [W-1:0]  count;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .mode(mode),
    .period(period), .duty(duty), .polarity(polarity),
    .pwm_out(pwm_out), .tick(tick), .load_pending(load_pending), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position inside the period (phase) plus active/shadow parameter sets.
  logic          m_mode, s_mode, m_pend, m_tick;
  int            m_p, s_p, m_k, m_c, m_lim;
  int            m_d [CH];
  int            s_d [CH];
  logic [CH-1:0] m_pwm;

  function automatic int mlen(input logic md, input int p);
    if (p == 0) return 1;
    if (!md) return p;
    if (p <= 1) return 1;
    return 2 * (p - 1);
  endfunction

  function automatic int mcnt(input logic md, input int p, input int k);
    if (p == 0 || !md) return (p == 0) ? 0 : k;
    if (k <= p - 1) return k;
    return 2 * (p - 1) - k;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; s_mode = 0; m_pend = 0; m_tick = 0; m_pwm = '0;
      m_p = 0; s_p = 0; m_k = 0;
      for (int i = 0; i < CH; i++) begin m_d[i] = 0; s_d[i] = 0; end
    end else if (!enable) begin
      if (m_pend) begin m_mode = s_mode; m_p = s_p; m_d = s_d; m_pend = 0; end
      if (load) begin
        s_mode = mode; s_p = int'(period);
        for (int i = 0; i < CH; i++) s_d[i] = int'(duty[i*W +: W]);
        m_pend = 1;
      end
      m_k = 0; m_tick = 0; m_pwm = polarity;
    end else begin
      if (m_k == 0) begin
        if (load) begin
          m_mode = mode; m_p = int'(period);
          for (int i = 0; i < CH; i++) m_d[i] = int'(duty[i*W +: W]);
          m_pend = 0;
        end else if (m_pend) begin
          m_mode = s_mode; m_p = s_p; m_d = s_d; m_pend = 0;
        end
      end else if (load) begin
        s_mode = mode; s_p = int'(period);
        for (int i = 0; i < CH; i++) s_d[i] = int'(duty[i*W +: W]);
        m_pend = 1;
      end
      m_c    = mcnt(m_mode, m_p, m_k);
      m_tick = (m_p != 0) && (m_k == 0);
      for (int i = 0; i < CH; i++) begin
        m_lim    = (m_d[i] < m_p) ? m_d[i] : m_p;
        m_pwm[i] = ((m_p != 0) && (m_c < m_lim)) ^ polarity[i];
      end
      m_k = (m_k + 1) % mlen(m_mode, m_p);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_count", count, mcnt(m_mode, m_p, m_k));
      check("cyc_tick", tick, m_tick);
      check("cyc_pwm_out", pwm_out, m_pwm);
      check("cyc_load_pending", load_pending, m_pend);
    end
  end

  int hi [CH];
  int nticks;

  task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
    duty = {W'(d3), W'(d2), W'(d1), W'(d0)};
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick();
    int waited = 0;
    while (tick !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("tick_seen", tick, 1);
  endtask

  // Accumulate n samples starting at a tick; optional duty0 loads at sample la / lb.
  task automatic measure(input int n, input int la, input int da, input int lb, input int db);
    wait_tick();
    for (int i = 0; i < CH; i++) hi[i] = 0;
    nticks = 0;
    for (int s = 0; s < n; s++) begin
      if (s > 0) @(negedge clk);
      if (load) begin
        load = 1'b0;
        check("load_pending_set", load_pending, 1);
      end
      for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
      nticks += int'(tick);
      if (s == la) begin duty[W-1:0] = W'(da); load = 1'b1; end
      if (s == lb) begin duty[W-1:0] = W'(db); load = 1'b1; end
    end
  endtask

  task automatic restart(input logic md, input int p);
    enable = 1'b0; mode = md; period = W'(p); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    #3;
    check("rst_count", count, 0);
    check("rst_tick", tick, 0);
    check("rst_pwm_out", pwm_out, 0);
    check("rst_load_pending", load_pending, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_on = 1'b1;

    // Edge mode, load in the boundary cycle goes straight to active.
    mode = 1'b0; period = W'(10); set_duty(0, 3, 10, 15);
    enable = 1'b1;
    pulse_load();
    check("t1_direct_pending", load_pending, 0);
    measure(10, -1, 0, -1, 0);
    check("t1_hi0", hi[0], 0);
    check("t1_hi1", hi[1], 3);
    check("t1_hi2", hi[2], 10);
    check("t1_hi3", hi[3], 10);
    check("t1_ticks", nticks, 1);

    // Center mode P=5: counts 0,1,2,3,4,3,2,1; duty 2 is high at counts 0,1,1.
    set_duty(2, 1, 4, 5);
    restart(1'b1, 5);
    measure(16, -1, 0, -1, 0);
    check("t2_hi0", hi[0], 6);
    check("t2_hi1", hi[1], 2);
    check("t2_hi2", hi[2], 14);
    check("t2_hi3", hi[3], 16);
    check("t2_ticks", nticks, 2);

    // Shadowed duty update mid-period, and last load wins.
    set_duty(4, 0, 0, 0);
    restart(1'b0, 8);
    measure(8, 2, 6, -1, 0);
    check("t3_hi0_old", hi[0], 4);
    measure(8, -1, 0, -1, 0);
    check("t3_hi0_new", hi[0], 6);
    check("t3_pending_clear", load_pending, 0);
    measure(8, 1, 2, 3, 7);
    check("t3_hi0_keep", hi[0], 6);
    measure(8, -1, 0, -1, 0);
    check("t3_hi0_last", hi[0], 7);

    // Live polarity and enable toggling.
    polarity = 4'b0101;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("t4_dis_pwm", pwm_out, 4'b0101);
    check("t4_dis_count", count, 0);
    check("t4_dis_tick", tick, 0);
    @(negedge clk);
    @(negedge clk);
    check("t4_dis_count2", count, 0);
    enable = 1'b1;
    @(negedge clk);
    check("t4_en_tick", tick, 1);
    check("t4_en_count", count, 1);

    // P=0 stalls the counter; a load while P=0 applies immediately.
    wait_tick();
    period = '0;
    pulse_load();
    nticks = 0;
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      nticks += int'(tick);
    end
    check("t5_p0_ticks", nticks, 0);
    check("t5_p0_count", count, 0);
    check("t5_p0_pwm", pwm_out, 4'b0101);
    period = W'(4);
    pulse_load();
    check("t5_resume_pending", load_pending, 0);
    check("t5_resume_tick", tick, 1);
    measure(12, -1, 0, -1, 0);
    check("t5_ticks", nticks, 3);

    // Async reset with a pending shadow discards it.
    wait_tick();
    period = W'(3);
    pulse_load();
    check("t6_pending", load_pending, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_pwm", pwm_out, 0);
    check("t6_rst_tick", tick, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_pending", load_pending, 0);
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1'b0;
    for (int s = 0; s < 8; s++) @(negedge clk);
    check("t6_shadow_dropped", count, 0);
    check("t6_pending_after", load_pending, 0);

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
